wb_timer: RTL

- Wishbone slave peripheral with two 32-bit timers, each with compare match, auto-reload and a level interrupt.
- Occupies the system bus slave port at 0xF002xxxx; the interconnect feeds it through that port.
- The interrupt outputs drive the CPU interrupt_n vector, inverted externally.

---
 rtl/wb_timer.sv | 86 ++++++++
 1 files changed

// File: rtl/wb_timer.sv
`timescale 1ns/1ps
// wb_timer: Wishbone slave with two compare/auto-reload timers and level interrupts.
module wb_timer #(
   parameter int CLK_IN_MHZ    = 50,
   parameter int TIMER_COUNT_W = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   output logic        wb_ack_o,
   output logic [1:0]  intr_o
);
   localparam int W = TIMER_COUNT_W;
   logic acc, we, wr_status, unused;
   logic [2:0] a;
   logic [31:0] lane, rd;
   logic [1:0] trig_v, ie_v;
   logic [2:0] tcr_v [2];
   logic [W-1:0] cmp_v [2];
   logic [W-1:0] cnt_v [2];
   assign acc = wb_stb_i & wb_cyc_i & ~wb_ack_o;
   assign we = acc & wb_we_i;
   assign a = wb_adr_i[4:2];
   assign lane = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
   assign wr_status = we & wb_sel_i[0] & (a == 3'd0);
   assign intr_o = trig_v & ie_v;
   assign unused = ^{wb_adr_i[31:5], wb_adr_i[1:0], CLK_IN_MHZ[0]};
   for (genvar i = 0; i < 2; i++) begin : g_tmr
      logic wr_tcr, wr_cmp, wr_cnt, start, match;
      logic en, ar, ie, tg;
      logic [W-1:0] cmp_q, cnt_q;
      logic [31:0] cmp_w, cnt_w;
      assign wr_tcr = we & wb_sel_i[0] & (a == 3'(4 * i + 1));
      assign wr_cmp = we & (a == 3'(4 * i + 2));
      assign wr_cnt = we & (a == 3'(4 * i + 3));
      assign start = wr_tcr & wb_dat_i[3];
      assign match = en & (cnt_q == cmp_q);
      assign cmp_w = (32'(cmp_q) & ~lane) | (wb_dat_i & lane);
      assign cnt_w = (32'(cnt_q) & ~lane) | (wb_dat_i & lane);
      assign tcr_v[i] = {ie, ar, en};
      assign cmp_v[i] = cmp_q;
      assign cnt_v[i] = cnt_q;
      assign trig_v[i] = tg;
      assign ie_v[i] = ie;
      // CPU counter writes and START beat a same-edge match; a new match beats a W1C
      always_ff @(posedge clk_i or negedge rst_i)
         if (!rst_i) begin
            {en, ar, ie, tg} <= '0;
            cmp_q <= '0;
            cnt_q <= '0;
         end else begin
            if (wr_tcr) {ie, ar, en} <= {wb_dat_i[2:1], wb_dat_i[0] | wb_dat_i[3]};
            else if (match & ~ar & ~wr_cnt) en <= 1'b0;
            if (wr_cmp) cmp_q <= W'(cmp_w);
            cnt_q <= wr_cnt ? W'(cnt_w) : start | match ? '0 : en ? cnt_q + W'(1) : cnt_q;
            tg <= (match & ~wr_cnt & ~start) | (tg & ~(wr_status & wb_dat_i[i]));
         end
   end
   always_comb begin
      rd = '0;
      case (a)
         3'd0: rd = {30'd0, trig_v};
         3'd1: rd = {29'd0, tcr_v[0]};
         3'd2: rd = 32'(cmp_v[0]);
         3'd3: rd = 32'(cnt_v[0]);
         3'd5: rd = {29'd0, tcr_v[1]};
         3'd6: rd = 32'(cmp_v[1]);
         3'd7: rd = 32'(cnt_v[1]);
         default: rd = '0;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
      end else begin
         wb_ack_o <= acc;
         wb_dat_o <= acc ? rd : '0;
      end
endmodule
